// File: rtl/atan_octant_angle_pkg.sv
// Shared constants for the ratio/octant pattern matcher and the atan angle stage.
// BAM angles: 16-bit, 32768 = pi, wrapping mod 2^16.
package atan_octant_angle_pkg;

    typedef logic [15:0] bam_t;

    localparam bam_t BAM_PI      = 16'd32768;
    localparam bam_t BAM_HALF_PI = 16'd16384;
    localparam bam_t BAM_QTR_PI  = 16'd8192;

    localparam int unsigned RATIO_ONE_DEFAULT = 128;   // Q1.7 code for 1.0
    localparam int unsigned ATAN_C_DEFAULT    = 2847;  // 0.273*(4/pi)*8192

    // Octant codes produced by the pattern matcher; each selects one fold of a.
    typedef enum logic [2:0] {
        CASE_Q3_NEAR_X = 3'd0,  // -pi + a
        CASE_Q1_NEAR_X = 3'd1,  //  a
        CASE_Q2_NEAR_X = 3'd2,  //  pi - a
        CASE_Q4_NEAR_X = 3'd3,  // -a
        CASE_Q3_NEAR_Y = 3'd4,  // -pi/2 - a
        CASE_Q1_NEAR_Y = 3'd5,  //  pi/2 - a
        CASE_Q2_NEAR_Y = 3'd6,  //  pi/2 + a
        CASE_NEG_Y_FAR = 3'd7   // -pi/2 + a
    } case_flag_e;

endpackage

// File: rtl/atan_octant_angle_if.sv
// Streaming ratio/flag in, BAM angle out. No backpressure.
interface atan_octant_angle_if;
    import atan_octant_angle_pkg::*;

    logic       val_i;
    logic [7:0] ratio_i;
    logic [2:0] case_flag_i;
    bam_t       angle_o;
    logic       val_o;

    modport master (output val_i, ratio_i, case_flag_i, input angle_o, val_o);
    modport slave  (input val_i, ratio_i, case_flag_i, output angle_o, val_o);
endinterface

// File: rtl/atan_octant_angle_poly_core.sv
// atan_poly_core: clamp (S1), x*(1-x) product (S2), polynomial sum (S3).
// Optional macro ATAN_ROUND_EN: round half up on the coefficient term instead of truncating.
module atan_poly_core
    import atan_octant_angle_pkg::*;
#(
    parameter int unsigned ATAN_C    = ATAN_C_DEFAULT,
    parameter int unsigned RATIO_ONE = RATIO_ONE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [7:0]  ratio,
    input  case_flag_e  case_flag,
    output logic        out_valid,
    output logic [13:0] poly,
    output case_flag_e  out_flag
);

    localparam logic [7:0] ONE = 8'(RATIO_ONE);
`ifdef ATAN_ROUND_EN
    localparam logic [23:0] ROUND_BIAS = 24'd8192;
`else
    localparam logic [23:0] ROUND_BIAS = 24'd0;
`endif

    logic       v1, v2, v3;
    logic [7:0] x_clamped;
    logic [7:0] x1, omx1, x2;
    logic [13:0] p2;
    logic [9:0]  corr;
    case_flag_e  f1, f2, f3;
    logic [13:0] a3;

    // Ratios above 1.0 saturate at 1.0.
    always_comb begin
        x_clamped = (ratio > ONE) ? ONE : ratio;
    end

    // Coefficient term (ATAN_C*p)>>14; at most 711, so 10 bits suffice.
    always_comb begin
        corr = 10'((24'(ATAN_C) * {10'b0, p2} + ROUND_BIAS) >> 14);
    end

    // Valid pipeline; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= valid;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // S1: register clamped x, its complement and the flag.
    always_ff @(posedge clk) begin
        if (valid) begin
            x1   <= x_clamped;
            omx1 <= ONE - x_clamped;
            f1   <= case_flag;
        end
    end

    // S2: p = x*(1-x), peaks at 4096 for x = 64.
    always_ff @(posedge clk) begin
        if (v1) begin
            p2 <= {6'b0, x1} * {6'b0, omx1};
            x2 <= x1;
            f2 <= f1;
        end
    end

    // S3: a = (pi/4)x + c*x(1-x) in BAM units, 0..8192.
    always_ff @(posedge clk) begin
        if (v2) begin
            a3 <= {x2, 6'b0} + {4'b0, corr};
            f3 <= f2;
        end
    end

    assign out_valid = v3;
    assign poly      = a3;
    assign out_flag  = f3;

endmodule

// File: rtl/atan_octant_angle.sv
// atan_octant_angle: 4-stage atan approximation plus octant fold to a full-circle BAM angle.
// Optional macro ATAN_ROUND_EN (passed through to atan_poly_core) selects rounding in S3.
module atan_octant_angle
    import atan_octant_angle_pkg::*;
#(
    parameter int unsigned ATAN_C    = ATAN_C_DEFAULT,
    parameter int unsigned RATIO_ONE = RATIO_ONE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    atan_octant_angle_if.slave  bus
);

    logic        v3;
    logic [13:0] a3;
    case_flag_e  f3;
    bam_t        a16;
    bam_t        folded;

    atan_poly_core #(
        .ATAN_C    (ATAN_C),
        .RATIO_ONE (RATIO_ONE)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .valid     (bus.val_i),
        .ratio     (bus.ratio_i),
        .case_flag (case_flag_e'(bus.case_flag_i)),
        .out_valid (v3),
        .poly      (a3),
        .out_flag  (f3)
    );

    // S4 fold: every case is a modular add/subtract of a against a pi/2 multiple.
    always_comb begin
        a16    = {2'b0, a3};
        folded = '0;
        unique case (f3)
            CASE_Q3_NEAR_X: folded = BAM_PI + a16;
            CASE_Q1_NEAR_X: folded = a16;
            CASE_Q2_NEAR_X: folded = BAM_PI - a16;
            CASE_Q4_NEAR_X: folded = '0 - a16;
            CASE_Q3_NEAR_Y: folded = (BAM_PI + BAM_HALF_PI) - a16;
            CASE_Q1_NEAR_Y: folded = BAM_HALF_PI - a16;
            CASE_Q2_NEAR_Y: folded = BAM_HALF_PI + a16;
            CASE_NEG_Y_FAR: folded = (BAM_PI + BAM_HALF_PI) + a16;
        endcase
    end

    // Output register: angle holds between valid pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.val_o   <= 1'b0;
            bus.angle_o <= '0;
        end else begin
            bus.val_o <= v3;
            if (v3) begin
                bus.angle_o <= folded;
            end
        end
    end

endmodule

// File: tb/tb_atan_octant_angle.sv
// Bench for atan_octant_angle: constant-table corner cases, an atan2 sanity burst,
// reset-during-burst sequence and randomized traffic against an arithmetic model.
module tb_atan_octant_angle;

    typedef struct {
        int unsigned due;
        logic [15:0] exp;
    } exp_t;

    typedef struct {
        logic [2:0]  flag;
        logic [7:0]  ratio;
        logic [15:0] exp;
    } vec_t;

`ifdef ATAN_ROUND_EN
    localparam logic [15:0] EXP_F4_R64 = 16'hAD38;  // -21192
    localparam int          RND        = 8192;
`else
    localparam logic [15:0] EXP_F4_R64 = 16'hAD39;  // -21191
    localparam int          RND        = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int unsigned cyc = 0;
    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];
    logic [15:0] got[$];
    exp_t mon_e;
    vec_t tbl[11];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    atan_octant_angle_if bus();

    atan_octant_angle #(.ATAN_C(2847), .RATIO_ONE(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: a = 64x + floor((2847*x*(128-x) [+8192]) / 16384), then octant fold.
    function automatic logic [15:0] model(input int flag, input int ratio);
        int x, a, ang;
        x = (ratio > 128) ? 128 : ratio;
        a = x * 64 + (2847 * x * (128 - x) + RND) / 16384;
        case (flag)
            0: ang = -32768 + a;
            1: ang = a;
            2: ang = 32768 - a;
            3: ang = -a;
            4: ang = -16384 - a;
            5: ang = 16384 - a;
            6: ang = 16384 + a;
            default: ang = -16384 + a;
        endcase
        return 16'(ang);
    endfunction

    // True atan of the ratio folded the same way, in BAM.
    function automatic logic [15:0] golden(input int flag, input int ratio);
        real t, ang;
        int x;
        x = (ratio > 128) ? 128 : ratio;
        t = $atan(real'(x) / 128.0) * 32768.0 / 3.14159265358979;
        case (flag)
            0: ang = -32768.0 + t;
            1: ang = t;
            2: ang = 32768.0 - t;
            3: ang = -t;
            4: ang = -16384.0 - t;
            5: ang = 16384.0 - t;
            6: ang = 16384.0 + t;
            default: ang = -16384.0 + t;
        endcase
        return 16'(int'(ang));
    endfunction

    // Scoreboard: every val_o pulse must match the oldest expectation on its exact cycle.
    always @(negedge clk) begin
        if (bus.val_o === 1'b1) begin
            vectors++;
            if (q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_val_o cyc=%0d angle=%h required no pulse", cyc, bus.angle_o);
            end else begin
                mon_e = q.pop_front();
                got.push_back(bus.angle_o);
                if (bus.angle_o !== mon_e.exp || cyc != mon_e.due) begin
                    miscompares++;
                    $display("FAIL angle cyc=%0d angle=%h required %h at cyc %0d",
                             cyc, bus.angle_o, mon_e.exp, mon_e.due);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            vectors++;
            miscompares++;
            $display("FAIL missing_val_o cyc=%0d val_o=%b required 1 (exp %h)", cyc, bus.val_o, q[0].exp);
            void'(q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [7:0] r, input logic [15:0] e);
        exp_t item;
        bus.val_i       = 1'b1;
        bus.case_flag_i = f;
        bus.ratio_i     = r;
        item.due = cyc + 4;
        item.exp = e;
        q.push_back(item);
        tick();
        bus.val_i = 1'b0;
    endtask

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout pending=%0d required 0", q.size());
            q.delete();
        end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout time=%0t required finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic signed [15:0] d;
        logic [15:0] g;
        int r;

        tbl[0]  = '{3'd1, 8'd0,   16'h0000};
        tbl[1]  = '{3'd1, 8'd128, 16'h2000};
        tbl[2]  = '{3'd2, 8'd128, 16'h6000};
        tbl[3]  = '{3'd3, 8'd128, 16'hE000};
        tbl[4]  = '{3'd4, 8'd64,  EXP_F4_R64};
        tbl[5]  = '{3'd5, 8'd0,   16'h4000};
        tbl[6]  = '{3'd0, 8'd0,   16'h8000};
        tbl[7]  = '{3'd6, 8'd200, 16'h6000};
        tbl[8]  = '{3'd5, 8'd128, 16'h2000};
        tbl[9]  = '{3'd3, 8'd0,   16'h0000};
        tbl[10] = '{3'd7, 8'd0,   16'hC000};

        rst = 1'b1;
        bus.val_i = 1'b0;
        bus.ratio_i = '0;
        bus.case_flag_i = '0;
        repeat (3) tick();
        check("reset_val_o", {15'b0, bus.val_o}, 16'h0000);
        check("reset_angle_o", bus.angle_o, 16'h0000);
        rst = 1'b0;
        tick();

        // Constant corner-case table.
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].flag, tbl[i].ratio, tbl[i].exp);
            tick();
        end
        drain();

        // Back-to-back burst over all octants, also compared to true atan2.
        got.delete();
        for (int k = 0; k < 8; k++) begin
            send(3'(k), 8'(10 + 16 * k), model(k, 10 + 16 * k));
        end
        drain();
        check("burst_count", 16'(got.size()), 16'd8);
        for (int k = 0; k < 8 && k < got.size(); k++) begin
            g = golden(k, 10 + 16 * k);
            d = $signed(got[k] - g);
            vectors++;
            if (d > 16'sd40 || d < -16'sd40) begin
                miscompares++;
                $display("FAIL atan2_err flag=%0d actual=%h required %h +-40", k, got[k], g);
            end
        end

        // Reset two cycles into a burst: nothing from the burst may emerge.
        send(3'd1, 8'd50, model(1, 50));
        send(3'd2, 8'd90, model(2, 90));
        rst = 1'b1;
        bus.val_i = 1'b1;
        bus.case_flag_i = 3'd6;
        bus.ratio_i = 8'd30;
        q.delete();
        tick();
        rst = 1'b0;
        bus.val_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            check("post_reset_val_o", {15'b0, bus.val_o}, 16'h0000);
            tick();
        end
        send(3'd7, 8'd77, model(7, 77));
        drain();

        // Randomized traffic with idle gaps and out-of-range ratios.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                r = (($urandom_range(0, 7)) == 0) ? 128 : int'($urandom_range(0, 255));
                send(3'($urandom_range(0, 7)), 8'(r), model(0, 0));
                q[q.size() - 1].exp = model(int'(bus.case_flag_i), r);
            end else begin
                tick();
            end
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
